// File: rtl/mac_cfg_loader_if.sv
// Word-stream handshake into mac_cfg_loader.
// The in_parity wire exists only when MAC_CFG_PARITY_EN is defined.
interface mac_cfg_loader_if #(
  parameter int CFG_IN_WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [CFG_IN_WIDTH-1:0] in_data;
`ifdef MAC_CFG_PARITY_EN
  logic                    in_parity;
`endif

`ifdef MAC_CFG_PARITY_EN
  modport master (output in_valid, output in_data, output in_parity, input in_ready);
  modport slave  (input in_valid, input in_data, input in_parity, output in_ready);
`else
  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
`endif
endinterface

// File: rtl/mac_cfg_loader.sv
// Serial configuration loader for the MAC cluster: assembles narrow words in a
// staging register and commits them atomically to cfg. Optional MAC_CFG_PARITY_EN.
module mac_cfg_loader #(
  parameter int  MAC_CONF_WIDTH = 4,
  parameter int  MAC_ACC_WIDTH  = 32,
  parameter int  CFG_IN_WIDTH   = 8,
  localparam int CFG_WIDTH      = 4*MAC_ACC_WIDTH + MAC_CONF_WIDTH,
  localparam int NUM_WORDS      = (CFG_WIDTH + CFG_IN_WIDTH - 1) / CFG_IN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  mac_cfg_loader_if.slave      in_if,
  input  logic                 en_in,
  output logic                 en,
  output logic                 busy,
  output logic [CFG_WIDTH-1:0] cfg,
  output logic                 cset,
  output logic                 cfg_err
);

  // state    | meaning
  // S_IDLE   | no load in flight, in_ready low
  // S_LOAD   | accepting words into staging
  // S_COMMIT | cfg holds the new word, cset high for this one cycle
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;

  localparam int                CNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_WORDS - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CFG_WIDTH-1:0] staging_q, staging_d, staging_wr;
  logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
  logic                 hs;
  logic                 start_ok;
  logic                 abort;

  // A start in LOAD wins over a simultaneous handshake.
  assign hs       = (state_q == S_LOAD) & in_if.in_valid & ~start;
  assign start_ok = start & (state_q != S_COMMIT);

  // Bits of the last word beyond CFG_WIDTH have no staging bit and fall away.
  for (genvar i = 0; i < CFG_WIDTH; i++) begin : g_stage
    assign staging_wr[i] = (hs && cnt_q == CNT_W'(i / CFG_IN_WIDTH))
                           ? in_if.in_data[i % CFG_IN_WIDTH] : staging_q[i];
  end

`ifdef MAC_CFG_PARITY_EN
  logic err_q, err_d;
  logic word_bad;

  assign word_bad = hs & (^{in_if.in_data, in_if.in_parity});

  always_comb begin
    err_d = err_q;
    if (start_ok)      err_d = 1'b0;
    else if (word_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  // An error on the final word itself also suppresses the commit.
  assign abort   = err_q | word_bad;
  assign cfg_err = err_q;
`else
  assign abort   = 1'b0;
  assign cfg_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cfg_d     = cfg_q;
    staging_d = staging_wr;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (start) begin
          cnt_d = '0;
        end else if (hs) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            if (abort) begin
              state_d = S_IDLE;
            end else begin
              // cfg must already hold the new value during the cset cycle.
              state_d = S_COMMIT;
              cfg_d   = staging_wr;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      staging_q <= '0;
      cfg_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      staging_q <= staging_d;
      cfg_q     <= cfg_d;
    end
  end

  assign in_if.in_ready = (state_q == S_LOAD);
  assign busy           = (state_q != S_IDLE);
  assign cset           = (state_q == S_COMMIT);
  assign en             = en_in & ~busy;
  assign cfg            = cfg_q;

endmodule
